arduino_uart_tx: RTL and testbench

UART transmitter for the FPGA-to-Arduino direction. It is the counterpart of the arduino_uart_buffer receiver. It accepts a parallel byte over a valid/ready handshake and serialises it on one line: 1 start bit, BITS_N data bits, STOP_BITS stop bits. A one-entry holding buffer allows the next byte to be accepted mid-frame, so frames can be sent back-to-back with no idle gap.

---
 rtl/arduino_uart_tx.sv | 151 +++++++++++++++
 tb/tb_arduino_uart_tx.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/arduino_uart_tx.sv
// UART transmitter for the FPGA-to-Arduino link: start bit, BITS_N data bits, STOP_BITS stop bits.
// One-entry holding buffer lets the next byte be accepted mid-frame so frames run back-to-back.
module arduino_uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int BITS_N       = 8,
  parameter bit MSB_FIRST    = 1'b1,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk_50,
  input  logic              reset,
  input  logic [BITS_N-1:0] tx_data,
  input  logic              valid,
  output logic              ready,
  output logic              uart_out,
  output logic              busy
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = $clog2(BITS_N + STOP_BITS + 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(BITS_N - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     clk_cnt, clk_cnt_nxt;
  logic [BW-1:0]     bit_cnt, bit_cnt_nxt;
  logic [BITS_N-1:0] shift, shift_nxt, shifted;
  logic [BITS_N-1:0] hold, hold_nxt;
  logic              hold_full, hold_full_nxt;
  logic              ready_nxt, uart_nxt, busy_nxt;
  logic              accept, bit_end, frame_end;

  function automatic logic first_bit(input logic [BITS_N-1:0] v);
    return MSB_FIRST ? v[BITS_N-1] : v[0];
  endfunction

  assign accept    = valid && ready;
  assign bit_end   = (clk_cnt == CNT_LAST);
  assign frame_end = (state == STOP) && bit_end && (bit_cnt == STOP_LAST);
  assign shifted   = MSB_FIRST ? (shift << 1) : (shift >> 1);

  always_comb begin
    state_nxt     = state;
    clk_cnt_nxt   = clk_cnt;
    bit_cnt_nxt   = bit_cnt;
    shift_nxt     = shift;
    hold_nxt      = hold;
    hold_full_nxt = hold_full;
    uart_nxt      = uart_out;
    busy_nxt      = busy;

    if (state != IDLE) begin
      clk_cnt_nxt = bit_end ? '0 : clk_cnt + 1'b1;
    end

    // A handshake mid-frame parks the byte; at the frame boundary it goes straight to the shifter.
    if ((state != IDLE) && accept && !frame_end) begin
      hold_nxt      = tx_data;
      hold_full_nxt = 1'b1;
    end

    case (state)
      IDLE: begin
        uart_nxt = 1'b1;
        if (accept) begin
          shift_nxt   = tx_data;
          state_nxt   = START;
          uart_nxt    = 1'b0;
          busy_nxt    = 1'b1;
          clk_cnt_nxt = '0;
          bit_cnt_nxt = '0;
        end
      end
      START: begin
        if (bit_end) begin
          state_nxt   = DATA;
          bit_cnt_nxt = '0;
          uart_nxt    = first_bit(shift);
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_cnt == DATA_LAST) begin
            state_nxt   = STOP;
            bit_cnt_nxt = '0;
            uart_nxt    = 1'b1;
          end else begin
            bit_cnt_nxt = bit_cnt + 1'b1;
            shift_nxt   = shifted;
            uart_nxt    = first_bit(shifted);
          end
        end
      end
      STOP: begin
        if (frame_end) begin
          bit_cnt_nxt = '0;
          if (hold_full) begin
            shift_nxt     = hold;
            hold_full_nxt = 1'b0;
            state_nxt     = START;
            uart_nxt      = 1'b0;
          end else if (accept) begin
            shift_nxt = tx_data;
            state_nxt = START;
            uart_nxt  = 1'b0;
          end else begin
            state_nxt = IDLE;
            uart_nxt  = 1'b1;
            busy_nxt  = 1'b0;
          end
        end else if (bit_end) begin
          bit_cnt_nxt = bit_cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        uart_nxt  = 1'b1;
        busy_nxt  = 1'b0;
      end
    endcase

    ready_nxt = !hold_full_nxt;
  end

  always_ff @(posedge clk_50 or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      clk_cnt   <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      ready     <= 1'b0;
      uart_out  <= 1'b1;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      clk_cnt   <= clk_cnt_nxt;
      bit_cnt   <= bit_cnt_nxt;
      shift     <= shift_nxt;
      hold      <= hold_nxt;
      hold_full <= hold_full_nxt;
      ready     <= ready_nxt;
      uart_out  <= uart_nxt;
      busy      <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_arduino_uart_tx.sv
// Directed bench for arduino_uart_tx: short-bit instances for slot-level checks and a
// default-rate instance feeding a serial receiver model for back-to-back loopback.
module tb_arduino_uart_tx;

  localparam int CPB_D = 434;

  logic clk_50 = 1'b0;
  always #10 clk_50 = ~clk_50;

  logic       reset;
  logic [7:0] data_m, data_l, data_d;
  logic       valid_m, valid_l, valid_d;
  logic       rdy_m, rdy_l, rdy_d;
  logic       uart_m, uart_l, uart_d;
  logic       busy_m, busy_l, busy_d;

  int n_tests = 0;
  int n_fail  = 0;
  int sel     = 0;
  logic obs_uart, obs_busy, obs_rdy;

  arduino_uart_tx #(.CLKS_PER_BIT(4), .BITS_N(8), .MSB_FIRST(1'b1), .STOP_BITS(1)) dut_m (
    .clk_50(clk_50), .reset(reset), .tx_data(data_m), .valid(valid_m),
    .ready(rdy_m), .uart_out(uart_m), .busy(busy_m));

  arduino_uart_tx #(.CLKS_PER_BIT(4), .BITS_N(8), .MSB_FIRST(1'b0), .STOP_BITS(1)) dut_l (
    .clk_50(clk_50), .reset(reset), .tx_data(data_l), .valid(valid_l),
    .ready(rdy_l), .uart_out(uart_l), .busy(busy_l));

  arduino_uart_tx #(.CLKS_PER_BIT(CPB_D), .BITS_N(8), .MSB_FIRST(1'b1), .STOP_BITS(1)) dut_d (
    .clk_50(clk_50), .reset(reset), .tx_data(data_d), .valid(valid_d),
    .ready(rdy_d), .uart_out(uart_d), .busy(busy_d));

  always_comb begin
    obs_uart = uart_m;
    obs_busy = busy_m;
    obs_rdy  = rdy_m;
    if (sel == 1) begin
      obs_uart = uart_l;
      obs_busy = busy_l;
      obs_rdy  = rdy_l;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_50);
    #1;
  endtask

  task automatic drive(input int s, input logic [7:0] d, input logic v);
    case (s)
      0: begin data_m = d; valid_m = v; end
      1: begin data_l = d; valid_l = v; end
      default: begin data_d = d; valid_d = v; end
    endcase
  endtask

  // One 40-cycle frame on the selected short-bit instance; exp holds the 10 slot levels, slot 0 in bit 9.
  task automatic capture(input int s, input logic [7:0] d, input logic [9:0] exp, input string tag);
    logic [9:0] got;
    int err, bcnt;
    sel = s;
    drive(s, d, 1'b1);
    tick();
    drive(s, 8'h00, 1'b0);
    check({tag, "_hs_uart"}, obs_uart, 0);
    check({tag, "_hs_busy"}, obs_busy, 1);
    check({tag, "_hs_ready"}, obs_rdy, 1);
    got = '0; err = 0; bcnt = 0;
    for (int k = 0; k < 40; k++) begin
      if (k > 0) tick();
      if (obs_uart !== exp[9 - k/4]) err++;
      if (k % 4 == 2) got[9 - k/4] = obs_uart;
      if (obs_busy === 1'b1) bcnt++;
    end
    tick();
    check({tag, "_slots"}, got, exp);
    check({tag, "_cycle_err"}, err, 0);
    check({tag, "_busy_cycles"}, bcnt, 40);
    check({tag, "_end_busy"}, obs_busy, 0);
    check({tag, "_end_uart"}, obs_uart, 1);
  endtask

  // Serial receiver model on the default-rate line: samples mid-bit, MSB first.
  logic [7:0] rx_q[$];
  int         rx_t[$];
  int         rx_err = 0;
  int         cyc = 0;
  always @(posedge clk_50) cyc <= cyc + 1;

  initial begin
    logic [7:0] b;
    int t0;
    b = '0;
    forever begin
      @(negedge uart_d);
      @(negedge clk_50);
      t0 = cyc;
      repeat (CPB_D/2 - 1) @(negedge clk_50);
      if (uart_d !== 1'b0) rx_err++;
      for (int i = 0; i < 8; i++) begin
        repeat (CPB_D) @(negedge clk_50);
        b = {b[6:0], uart_d};
      end
      repeat (CPB_D) @(negedge clk_50);
      if (uart_d !== 1'b1) rx_err++;
      rx_q.push_back(b);
      rx_t.push_back(t0);
    end
  end

  initial begin
    int err, err_rdy, bcnt;
    logic [79:0] exp80;
    logic [7:0] lb_bytes[4];
    int idx;
    logic hs;

    reset = 1'b0;
    drive(0, 8'hA5, 1'b1);
    drive(1, 8'h00, 1'b0);
    drive(2, 8'h00, 1'b0);

    // Reset held with valid asserted: line idle, nothing accepted.
    err = 0;
    repeat (6) begin
      tick();
      if (uart_m !== 1'b1 || busy_m !== 1'b0 || rdy_m !== 1'b0) err++;
    end
    check("rst_hold_err", err, 0);
    check("rst_uart", uart_m, 1);
    check("rst_busy", busy_m, 0);
    check("rst_ready", rdy_m, 0);
    reset = 1'b1;
    #1;
    check("rel_ready_pre_edge", rdy_m, 0);
    tick();
    drive(0, 8'h00, 1'b0);
    check("rel_ready", rdy_m, 1);
    check("rel_uart", uart_m, 1);
    check("rel_busy", busy_m, 0);
    err = 0;
    repeat (5) begin
      tick();
      if (uart_m !== 1'b1 || busy_m !== 1'b0) err++;
    end
    check("rel_idle_err", err, 0);

    capture(0, 8'hA5, 10'b0101001011, "msb_a5");
    capture(1, 8'hA5, 10'b0101001011, "lsb_a5");
    capture(1, 8'h01, 10'b0100000001, "lsb_01");

    // Back-to-back 0x3C then 0xC3; a third byte offered while the buffer is full.
    sel = 0;
    exp80 = {{4{1'b0}}, {4{1'b0}}, {4{1'b0}}, {4{1'b1}}, {4{1'b1}},
             {4{1'b1}}, {4{1'b1}}, {4{1'b0}}, {4{1'b0}}, {4{1'b1}},
             {4{1'b0}}, {4{1'b1}}, {4{1'b1}}, {4{1'b0}}, {4{1'b0}},
             {4{1'b0}}, {4{1'b0}}, {4{1'b1}}, {4{1'b1}}, {4{1'b1}}};
    drive(0, 8'h3C, 1'b1);
    tick();
    drive(0, 8'h00, 1'b0);
    err = 0; err_rdy = 0; bcnt = 0;
    for (int k = 0; k < 80; k++) begin
      if (k > 0) tick();
      if (uart_m !== exp80[79 - k]) err++;
      if (rdy_m !== ((k < 10 || k >= 40) ? 1'b1 : 1'b0)) err_rdy++;
      if (busy_m === 1'b1) bcnt++;
      if (k == 9)  drive(0, 8'hC3, 1'b1);
      if (k == 10) drive(0, 8'h99, 1'b1);
      if (k == 30) drive(0, 8'h00, 1'b0);
    end
    check("b2b_line_err", err, 0);
    check("b2b_ready_err", err_rdy, 0);
    check("b2b_busy_cycles", bcnt, 80);
    tick();
    check("b2b_end_busy", busy_m, 0);
    err = 0;
    repeat (20) begin
      tick();
      if (uart_m !== 1'b1 || busy_m !== 1'b0) err++;
    end
    check("b2b_third_not_sent", err, 0);

    // Reset during data bit 3 of 0xFF with 0x00 buffered.
    drive(0, 8'hFF, 1'b1);
    tick();
    drive(0, 8'h00, 1'b0);
    for (int k = 1; k <= 17; k++) begin
      tick();
      if (k == 5) drive(0, 8'h00, 1'b1);
      if (k == 6) begin
        drive(0, 8'h00, 1'b0);
        check("mid_buf_ready", rdy_m, 0);
      end
    end
    check("mid_busy_before", busy_m, 1);
    reset = 1'b0;
    #1;
    check("mid_rst_uart", uart_m, 1);
    check("mid_rst_busy", busy_m, 0);
    check("mid_rst_ready", rdy_m, 0);
    tick();
    reset = 1'b1;
    tick();
    check("mid_rel_ready", rdy_m, 1);
    err = 0;
    repeat (60) begin
      tick();
      if (uart_m !== 1'b1 || busy_m !== 1'b0) err++;
    end
    check("mid_no_resend", err, 0);

    // Reset during a start bit must force the line high immediately.
    drive(1, 8'h5A, 1'b1);
    tick();
    drive(1, 8'h00, 1'b0);
    check("start_bit_low", uart_l, 0);
    tick();
    reset = 1'b0;
    #1;
    check("start_rst_uart", uart_l, 1);
    check("start_rst_busy", busy_l, 0);
    tick();
    reset = 1'b1;
    err = 0;
    repeat (50) begin
      tick();
      if (uart_l !== 1'b1 || busy_l !== 1'b0) err++;
    end
    check("start_no_resend", err, 0);

    // Default-rate loopback: four frames back-to-back into the receiver model.
    lb_bytes = '{8'hAA, 8'h55, 8'h00, 8'hFF};
    idx = 0;
    drive(2, lb_bytes[0], 1'b1);
    for (int c = 0; c < 20000 && rx_q.size() < 4; c++) begin
      hs = valid_d && rdy_d;
      tick();
      if (hs) begin
        idx++;
        if (idx < 4) drive(2, lb_bytes[idx], 1'b1);
        else drive(2, 8'h00, 1'b0);
      end
    end
    check("lb_accepted", idx, 4);
    check("lb_frames", rx_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < rx_q.size()) check($sformatf("lb_byte%0d", i), rx_q[i], lb_bytes[i]);
    end
    for (int i = 1; i < 4; i++) begin
      if (i < rx_t.size()) check($sformatf("lb_gap%0d", i), rx_t[i] - rx_t[i-1], 10 * CPB_D);
    end
    check("lb_framing_err", rx_err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
